// File: rtl/uart_rx_param.sv
// Purpose : parametrised UART receiver with 3-sample majority vote, glitch/break handling.
// Latency : word presented one clk after the voting point of the last stop bit (+2 clk sync).
// Backpr. : single holding register; a frame completing while rxValid&!rxReady is dropped (rxOverrun).
//
// Ports: clk/reset (async, active-low); rxEn gates start detection and aborts a frame;
//        rxIn raw serial line; rxBusy frame in progress; rxValid/rxReady output handshake;
//        rxOut received word (LSB first on line); rxParityErr/rxFrameErr/rxBreak describe
//        the word in rxOut; rxOverrun sticky until the next handshake.
module uart_rx_param #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxEn,
  input  logic                 rxIn,
  output logic                 rxBusy,
  output logic                 rxValid,
  input  logic                 rxReady,
  output logic [DATA_BITS-1:0] rxOut,
  output logic                 rxParityErr,
  output logic                 rxFrameErr,
  output logic                 rxBreak,
  output logic                 rxOverrun
);

  localparam int BAUD_TICKS = BAUD_RATE * OVERSAMPLE;
  localparam int DIV_ROUND  = (CLOCK_RATE + BAUD_TICKS / 2) / BAUD_TICKS;
  localparam int DIV        = (DIV_ROUND < 1) ? 1 : DIV_ROUND;
  localparam int DIV_W      = $clog2(DIV + 1);
  localparam int SMP_W      = $clog2(OVERSAMPLE);
  localparam int CNT_W      = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SMP_W-1:0] SMP_FIRST = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_MID   = SMP_W'(OVERSAMPLE / 2);
  localparam logic [SMP_W-1:0] SMP_VOTE  = SMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, stateNext;

  logic                 syncA, syncB, rxPrev;
  logic [DIV_W-1:0]     divCnt;
  logic [SMP_W-1:0]     sampCnt;
  logic [CNT_W-1:0]     bitCnt;
  logic [1:0]           samples;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parErr, frameErr, anyOne, breakWait;
  logic                 tick, votePt, bitEnd, vote, startEdge, frameDone;

  assign tick      = (divCnt == DIV_LAST);
  assign votePt    = tick && (sampCnt == SMP_VOTE);
  assign bitEnd    = tick && (sampCnt == SMP_LAST);
  // Third sample is taken live at the voting tick.
  assign vote      = (samples[0] & samples[1]) | (samples[0] & syncB) | (samples[1] & syncB);
  // After a break the line must be seen high before a new edge counts.
  assign startEdge = rxEn && !breakWait && rxPrev && !syncB;
  assign rxBusy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    frameDone = 1'b0;
    case (state)
      IDLE:  if (startEdge) stateNext = START;
      START: begin
        if (votePt && vote) stateNext = IDLE;
        else if (bitEnd)    stateNext = DATA;
      end
      DATA:  if (bitEnd && bitCnt == DATA_LAST) stateNext = (PARITY != 0) ? PAR : STOP;
      PAR:   if (bitEnd) stateNext = STOP;
      // Completion at the last stop bit's voting point leaves half a bit to catch the next start.
      STOP: begin
        if (votePt && bitCnt == STOP_LAST) begin
          stateNext = IDLE;
          frameDone = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (!rxEn && state != IDLE) begin
      stateNext = IDLE;
      frameDone = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncA     <= 1'b1;
      syncB     <= 1'b1;
      rxPrev    <= 1'b1;
      divCnt    <= '0;
      sampCnt   <= '0;
      bitCnt    <= '0;
      samples   <= '0;
      shiftReg  <= '0;
      parErr    <= 1'b0;
      frameErr  <= 1'b0;
      anyOne    <= 1'b0;
      breakWait <= 1'b0;
    end else begin
      syncA  <= rxIn;
      syncB  <= syncA;
      rxPrev <= syncB;
      if (state == IDLE) begin
        divCnt  <= '0;
        sampCnt <= '0;
        bitCnt  <= '0;
        if (syncB) breakWait <= 1'b0;
        if (startEdge) begin
          parErr   <= 1'b0;
          frameErr <= 1'b0;
          anyOne   <= 1'b0;
        end
      end else begin
        divCnt <= tick ? '0 : divCnt + DIV_W'(1);
        if (tick) sampCnt <= (sampCnt == SMP_LAST) ? '0 : sampCnt + SMP_W'(1);
        if (tick && sampCnt == SMP_FIRST) samples[0] <= syncB;
        if (tick && sampCnt == SMP_MID)   samples[1] <= syncB;
        // Counter serves data bits then stop bits; cleared on every state change.
        if (bitEnd) bitCnt <= (stateNext == state) ? bitCnt + CNT_W'(1) : '0;
        if (votePt) begin
          case (state)
            DATA: begin
              shiftReg <= {vote, shiftReg[DATA_BITS-1:1]};
              anyOne   <= anyOne | vote;
            end
            PAR: begin
              parErr <= (^shiftReg) ^ vote ^ ODD_PAR;
              anyOne <= anyOne | vote;
            end
            STOP: begin
              if (!vote) frameErr <= 1'b1;
              anyOne <= anyOne | vote;
            end
            default: ;
          endcase
        end
        if (frameDone && !(anyOne | vote)) breakWait <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxValid     <= 1'b0;
      rxOut       <= '0;
      rxParityErr <= 1'b0;
      rxFrameErr  <= 1'b0;
      rxBreak     <= 1'b0;
      rxOverrun   <= 1'b0;
    end else begin
      if (rxValid && rxReady) rxOverrun <= 1'b0;
      if (frameDone) begin
        // A handshake in the same clk frees the holding register for the new word.
        if (!rxValid || rxReady) begin
          rxOut       <= shiftReg;
          rxParityErr <= parErr;
          rxFrameErr  <= frameErr | !vote;
          rxBreak     <= !(anyOne | vote);
          rxValid     <= 1'b1;
        end else begin
          rxOverrun <= 1'b1;
        end
      end else if (rxValid && rxReady) begin
        rxValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int BITCLK = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } word_t;

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       pbit;
    logic [1:0] stopV;
    word_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, rxEn, rxReady;
  logic [1:0] line;
  logic       busyA, validA, peA, feA, brkA, ovA;
  logic       busyB, validB, peB, feB, brkB, ovB;
  logic [7:0] outA, outB;

  int    checks = 0;
  int    errors = 0;
  word_t gotA[$];
  word_t gotB[$];
  logic  sawBusyA = 1'b0;
  vec_t  vecs[12];

  always #5 clk = ~clk;

  // A: 8N1, DIV=1, OS=16.  B: 8E2, DIV=2, OS=8.  Both 16 clk per bit.
  uart_rx_param #(.CLOCK_RATE(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rxIn(line[0]), .rxBusy(busyA),
    .rxValid(validA), .rxReady(rxReady), .rxOut(outA), .rxParityErr(peA),
    .rxFrameErr(feA), .rxBreak(brkA), .rxOverrun(ovA));

  uart_rx_param #(.CLOCK_RATE(1600000), .BAUD_RATE(100000), .OVERSAMPLE(8),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dutB (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rxIn(line[1]), .rxBusy(busyB),
    .rxValid(validB), .rxReady(rxReady), .rxOut(outB), .rxParityErr(peB),
    .rxFrameErr(feB), .rxBreak(brkB), .rxOverrun(ovB));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input int sel, input logic [7:0] d, input logic pbit,
                                 input logic [1:0] stopV, input logic [7:0] ed,
                                 input logic pe, input logic fe, input logic brk);
    vec_t v;
    v.sel = sel; v.d = d; v.pbit = pbit; v.stopV = stopV;
    v.exp = {ed, pe, fe, brk};
    return v;
  endfunction

  // Frame-level reference: what the line carried decides the word and its flags.
  function automatic word_t refModel(input int sel, input logic [7:0] d, input logic pbit,
                                     input logic [1:0] stopV);
    word_t w;
    int    ones;
    w.d = d;
    if (sel == 0) begin
      w.pe  = 1'b0;
      w.fe  = (stopV[0] == 1'b0);
      w.brk = (d == 8'h00) && (stopV[0] == 1'b0);
    end else begin
      ones  = $countones(d) + int'(pbit);
      w.pe  = (ones % 2) != 0;
      w.fe  = (stopV != 2'b11);
      w.brk = (d == 8'h00) && !pbit && (stopV == 2'b00);
    end
    return w;
  endfunction

  task automatic sendFrame(input int sel, input logic [7:0] d, input logic pbit,
                           input logic [1:0] stopV);
    logic [11:0] bits;
    int          n;
    if (sel == 0) begin
      bits = {2'b00, stopV[0], d, 1'b0};
      n = 10;
    end else begin
      bits = {stopV[1], stopV[0], pbit, d, 1'b0};
      n = 12;
    end
    for (int i = 0; i < n; i++) begin
      line[sel] = bits[i];
      repeat (BITCLK) @(negedge clk);
    end
    line[sel] = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      #1;
      if (validA && rxReady) begin w = {outA, peA, feA, brkA}; gotA.push_back(w); end
      if (validB && rxReady) begin w = {outB, peB, feB, brkB}; gotB.push_back(w); end
      if (busyA) sawBusyA = 1'b1;
    end
  end

  initial begin
    word_t exp;
    int    sel, gap;
    logic [7:0] d;
    logic  pbit;
    logic [1:0] stopV;

    vecs[0]  = mkVec(0, 8'hD6, 1'b0, 2'b11, 8'hD6, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mkVec(0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mkVec(0, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mkVec(0, 8'h55, 1'b0, 2'b00, 8'h55, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mkVec(0, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1);
    vecs[5]  = mkVec(1, 8'h5A, 1'b1, 2'b11, 8'h5A, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mkVec(1, 8'h5A, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mkVec(1, 8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mkVec(1, 8'h07, 1'b0, 2'b11, 8'h07, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mkVec(1, 8'h81, 1'b0, 2'b01, 8'h81, 1'b0, 1'b1, 1'b0);
    vecs[10] = mkVec(1, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1);
    vecs[11] = mkVec(1, 8'h00, 1'b1, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0);

    reset = 1'b0; rxEn = 1'b1; rxReady = 1'b1; line = 2'b11;
    repeat (3) @(negedge clk);
    #2;
    chk("reset A ctl", {busyA, validA, peA, feA, brkA, ovA}, 0);
    chk("reset A out", outA, 0);
    chk("reset B ctl", {busyB, validB, peB, feB, brkB, ovB}, 0);
    chk("reset B out", outB, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 12; i++) begin
      gotA.delete(); gotB.delete();
      sendFrame(vecs[i].sel, vecs[i].d, vecs[i].pbit, vecs[i].stopV);
      repeat (4) @(negedge clk);
      #2;
      if (vecs[i].sel == 0) begin
        chk($sformatf("vec%0d count", i), gotA.size(), 1);
        if (gotA.size() == 1) chk($sformatf("vec%0d word", i), gotA[0], vecs[i].exp);
      end else begin
        chk($sformatf("vec%0d count", i), gotB.size(), 1);
        if (gotB.size() == 1) chk($sformatf("vec%0d word", i), gotB[0], vecs[i].exp);
      end
    end

    // Short low pulse: busy rises, start vote rejects it
    gotA.delete(); sawBusyA = 1'b0;
    line[0] = 1'b0;
    repeat (6) @(negedge clk);
    line[0] = 1'b1;
    repeat (40) @(negedge clk);
    #2;
    chk("glitch busy seen", sawBusyA, 1);
    chk("glitch busy end", busyA, 0);
    chk("glitch no word", gotA.size(), 0);

    // Overrun: two frames without consumer
    gotA.delete();
    rxReady = 1'b0;
    sendFrame(0, 8'h11, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    sendFrame(0, 8'h22, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    #2;
    chk("ovr valid", validA, 1);
    chk("ovr out", outA, 8'h11);
    chk("ovr flag", ovA, 1);
    @(negedge clk);
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
    #2;
    chk("ovr clr valid", validA, 0);
    chk("ovr clr flag", ovA, 0);
    chk("ovr handshake count", gotA.size(), 1);
    if (gotA.size() == 1) chk("ovr handshake word", gotA[0].d, 8'h11);
    rxReady = 1'b1;
    repeat (10) @(negedge clk);

    // Break: line low for 12 bit times
    gotA.delete();
    line[0] = 1'b0;
    repeat (12 * BITCLK) @(negedge clk);
    #2;
    chk("break count", gotA.size(), 1);
    if (gotA.size() == 1) chk("break word", gotA[0], {8'h00, 1'b0, 1'b1, 1'b1});
    chk("break no restart", busyA, 0);
    line[0] = 1'b1;
    repeat (20) @(negedge clk);
    gotA.delete();
    sendFrame(0, 8'h3C, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    #2;
    chk("post break count", gotA.size(), 1);
    if (gotA.size() == 1) chk("post break word", gotA[0], {8'h3C, 3'b000});

    // Abort with rxEn=0 at data bit 3
    gotA.delete();
    d = 8'hD6;
    line[0] = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      line[0] = d[i];
      repeat (BITCLK) @(negedge clk);
    end
    #2;
    chk("abort busy before", busyA, 1);
    rxEn = 1'b0;
    @(negedge clk);
    #2;
    chk("abort busy after", busyA, 0);
    for (int i = 3; i < 8; i++) begin
      line[0] = d[i];
      repeat (BITCLK) @(negedge clk);
    end
    line[0] = 1'b1;
    repeat (BITCLK) @(negedge clk);
    // Whole frame with rxEn low in IDLE is ignored
    sendFrame(0, 8'hA5, 1'b0, 2'b11);
    repeat (10) @(negedge clk);
    #2;
    chk("rxEn low no word", gotA.size(), 0);
    rxEn = 1'b1;
    repeat (10) @(negedge clk);
    sendFrame(0, 8'h5C, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    #2;
    chk("re-enable count", gotA.size(), 1);
    if (gotA.size() == 1) chk("re-enable word", gotA[0], {8'h5C, 3'b000});

    // Async reset mid-frame with a held word
    gotA.delete();
    rxReady = 1'b0;
    sendFrame(0, 8'h99, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    #2;
    chk("held before reset", validA, 1);
    line[0] = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    chk("busy before reset", busyA, 1);
    reset = 1'b0;
    #1;
    chk("reset mid ctl", {busyA, validA, peA, feA, brkA, ovA}, 0);
    chk("reset mid out", outA, 0);
    repeat (8 * BITCLK) @(negedge clk);
    line[0] = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    rxReady = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    chk("after reset quiet", {busyA, validA}, 0);
    chk("after reset no word", gotA.size(), 0);

    // Randomised frames against the frame-level model
    for (int i = 0; i < 30; i++) begin
      sel   = int'($urandom_range(0, 1));
      d     = 8'($urandom);
      pbit  = 1'($urandom);
      stopV = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      exp   = refModel(sel, d, pbit, stopV);
      gotA.delete(); gotB.delete();
      sendFrame(sel, d, pbit, stopV);
      gap = int'($urandom_range(2, 20));
      repeat (gap) @(negedge clk);
      #2;
      chk($sformatf("rand%0d count", i), gotA.size() + gotB.size(), 1);
      if (sel == 0 && gotA.size() == 1) chk($sformatf("rand%0d A word", i), gotA[0], exp);
      if (sel == 1 && gotB.size() == 1) chk($sformatf("rand%0d B word", i), gotB[0], exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
